// File: rtl/rxuart.sv
// ---------------------------------------------------------------------------
// rxuart - 8N1 UART receiver, receive-side partner of the board UART TX.
//
// Samples the asynchronous serial line at i_clk, deframes LSB-first bytes and
// holds each byte until a slow consumer acknowledges it. Framing errors (stop
// bit low) and overruns (new byte while the previous one is still pending)
// are reported as sticky flags cleared by i_ack.
//
// Ports:
//   i_clk        system clock (25 MHz on ULX3S)
//   i_rst_n      asynchronous active-low reset
//   i_uart_rx    serial line, idle high, asynchronous to i_clk
//   i_ack        consumer acknowledge (level, sampled every i_clk)
//   o_data       last good byte received
//   o_valid      o_data holds an unacknowledged byte
//   o_frame_err  sticky: stop bit sampled low
//   o_overrun    sticky: byte completed while o_valid was already set
//   o_busy       receiver is not idle
//
// States:
//   S_IDLE  | line idle, waiting for rx_s low (start edge)
//   S_START | half-bit wait, then confirm start bit still low
//   S_DATA  | sample 8 data bits at bit centres, LSB first
//   S_STOP  | sample stop bit; publish byte or flag framing error
//   S_BREAK | line held low after a framing error; wait for high
// ---------------------------------------------------------------------------
module rxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd2604
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  input  logic       i_ack,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [23:0] HALF_BAUD_M1 = (CLOCKS_PER_BAUD >> 1) - 24'd1;
  localparam logic [23:0] FULL_BAUD_M1 = CLOCKS_PER_BAUD - 24'd1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t      state;
  logic        rx_meta;
  logic        rx_s;
  logic [23:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        baud_done;

  // Two-flop synchroniser; flops reset to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign baud_done = (baud_cnt == 24'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      baud_cnt    <= 24'd0;
      bit_cnt     <= 3'd0;
      shift       <= 8'd0;
      o_data      <= 8'd0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      // Acknowledge clears the flags; the state machine below may override
      // these on the same edge (new byte or new framing error wins).
      if (i_ack) begin
        o_valid     <= 1'b0;
        o_frame_err <= 1'b0;
        o_overrun   <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_BAUD_M1;
            state    <= S_START;
            o_busy   <= 1'b1;
          end
        end

        S_START: begin
          if (baud_done) begin
            if (!rx_s) begin
              baud_cnt <= FULL_BAUD_M1;
              bit_cnt  <= 3'd0;
              state    <= S_DATA;
            end else begin
              // Start bit did not survive to mid-bit: treat as a glitch.
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end

        S_DATA: begin
          if (baud_done) begin
            shift    <= {rx_s, shift[7:1]};
            baud_cnt <= FULL_BAUD_M1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end

        S_STOP: begin
          if (baud_done) begin
            if (rx_s) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              // Overrun only if the previous byte is still pending and is not
              // being acknowledged on this very edge.
              if (o_valid && !i_ack) begin
                o_overrun <= 1'b1;
              end
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end else begin
              o_frame_err <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt - 24'd1;
          end
        end

        S_BREAK: begin
          // Holding here keeps a break condition from producing a stream of
          // bogus all-zero frames and repeated framing errors.
          if (rx_s) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rxuart.sv
module tb_rxuart;

  localparam int CPB = 16;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_uart_rx;
  logic       i_ack;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int n_checks;
  int n_fail;
  int cyc;
  int rise_cyc;
  int fe_rises;
  int busy_seen;
  logic prev_v;
  logic prev_fe;

  rxuart #(.CLOCKS_PER_BAUD(24'd16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_uart_rx   (i_uart_rx),
    .i_ack       (i_ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    cyc       = 0;
    rise_cyc  = -1;
    fe_rises  = 0;
    busy_seen = 0;
    prev_v    = o_valid;
    prev_fe   = o_frame_err;
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge i_clk);
    #1;
    cyc++;
    if (o_valid && !prev_v && rise_cyc < 0) rise_cyc = cyc;
    if (o_frame_err && !prev_fe) fe_rises++;
    if (o_busy) busy_seen = 1;
    prev_v  = o_valid;
    prev_fe = o_frame_err;
  endtask

  task automatic hold(input int n, input logic lvl);
    i_uart_rx = lvl;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic ack_pulse();
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
  endtask

  // Drives one 10-bit frame; i_ack is raised only during cycle ack_cyc
  // (cycle 0 = first cycle the pin is low).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ack_cyc);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    mon_clear();
    for (int k = 0; k < 10 * CPB; k++) begin
      i_uart_rx = bits[k / CPB];
      i_ack     = (k == ack_cyc);
      step();
    end
    i_ack = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    i_rst_n   = 1'b0;
    i_uart_rx = 1'b1;
    i_ack     = 1'b0;
    mon_clear();

    // Reset state
    hold(3, 1'b1);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_ferr", o_frame_err, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    i_rst_n = 1'b1;
    hold(4, 1'b1);
    check("rel_busy", o_busy, 1'b0);
    check("rel_overrun", o_overrun, 1'b0);

    // Single byte 0x41 with latency 2+8+144+1
    send_frame(8'h41, 1'b1, -1);
    check("b41_latency", rise_cyc, 155);
    check("b41_data", o_data, 8'h41);
    check("b41_overrun", o_overrun, 1'b0);
    hold(20, 1'b1);
    check("b41_held", o_valid, 1'b1);
    ack_pulse();
    check("b41_ack_valid", o_valid, 1'b0);
    check("b41_ack_data", o_data, 8'h41);

    // Glitch: 4-cycle low pulse
    mon_clear();
    hold(4, 1'b0);
    hold(40, 1'b1);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", o_busy, 1'b0);
    check("glitch_no_valid", rise_cyc, -1);
    check("glitch_no_ferr", o_frame_err, 1'b0);

    // Framing error + 40-bit break
    send_frame(8'h3C, 1'b0, -1);
    hold(40 * CPB, 1'b0);
    check("brk_busy", o_busy, 1'b1);
    hold(3 * CPB, 1'b1);
    check("ferr_once", fe_rises, 1);
    check("ferr_flag", o_frame_err, 1'b1);
    check("ferr_valid", o_valid, 1'b0);
    check("ferr_data_kept", o_data, 8'h41);
    check("ferr_idle", o_busy, 1'b0);
    ack_pulse();
    check("ferr_ack", o_frame_err, 1'b0);
    send_frame(8'h5A, 1'b1, -1);
    check("b5a_latency", rise_cyc, 155);
    check("b5a_data", o_data, 8'h5A);
    check("b5a_ferr", fe_rises, 0);
    ack_pulse();

    // Overrun: 0x11 then 0x22 back-to-back, no ack
    send_frame(8'h11, 1'b1, -1);
    check("ovr_first_flag", o_overrun, 1'b0);
    send_frame(8'h22, 1'b1, -1);
    check("ovr_data", o_data, 8'h22);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_flag", o_overrun, 1'b1);
    ack_pulse();
    check("ovr_ack_valid", o_valid, 1'b0);
    check("ovr_ack_flag", o_overrun, 1'b0);

    // Ack race: ack lands on the edge where 0x33 completes
    send_frame(8'h44, 1'b1, -1);
    send_frame(8'h55, 1'b1, -1);
    check("race_pre_ovr", o_overrun, 1'b1);
    send_frame(8'h33, 1'b1, 154);
    check("race_valid", o_valid, 1'b1);
    check("race_data", o_data, 8'h33);
    check("race_overrun", o_overrun, 1'b0);

    // Reset mid-frame with a pending byte
    hold(40, 1'b0);
    i_rst_n = 1'b0;
    step();
    check("mid_rst_data", o_data, 8'h00);
    check("mid_rst_valid", o_valid, 1'b0);
    i_uart_rx = 1'b1;
    hold(2, 1'b1);
    i_rst_n = 1'b1;
    hold(3, 1'b1);
    check("mid_rel_busy", o_busy, 1'b0);
    check("mid_rel_valid", o_valid, 1'b0);
    check("mid_rel_ovr", o_overrun, 1'b0);
    check("mid_rel_ferr", o_frame_err, 1'b0);
    send_frame(8'hA5, 1'b1, -1);
    check("ba5_latency", rise_cyc, 155);
    check("ba5_data", o_data, 8'hA5);
    hold(CPB, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
